// File: rtl/morse_key_pkg.sv
// Shared definitions for the Morse keypad controller: buffer depth, key codes
// and FSM state encoding.
// Imported by morse_key_ctrl; no ports.
package morse_key_pkg;

    localparam int MAX_SYM = 5;

    localparam logic [3:0] KEY_DOT    = 4'h1;
    localparam logic [3:0] KEY_DASH   = 4'h2;
    localparam logic [3:0] KEY_BS     = 4'hE;
    localparam logic [3:0] KEY_SUBMIT = 4'hF;
    localparam logic [3:0] KEY_CLR    = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

endpackage

// File: rtl/key_sync_edge.sv
// 2-flop synchronizer for the scanner's key flag plus a rising-edge pulse.
// Ports: clk, rst (async, active-high), flag_in (foreign domain), rise (1-cycle pulse, clk domain).
// The detector only arms after a real low sample, so a flag already high at reset release is ignored.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic flag_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic v1_q, v2_q;        // marks when s2_q holds a genuine post-reset sample
    logic armed_q, armed_d;

    always_comb begin
        armed_d = armed_q | (v2_q & ~s2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= flag_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            v1_q    <= 1'b1;
            v2_q    <= v1_q;
            armed_q <= armed_d;
        end
    end

    assign rise = armed_q & s2_q & ~s3_q;

endmodule

// File: rtl/morse_key_ctrl.sv
// Morse keypad controller: builds a dot/dash buffer from key presses and hands it off by valid/ready.
// Ports: clk, rst, key_pressed_flag/keyboard_val (scanner), code_valid/code_ready/code_bits/code_len
// (output word), sym_count (display), err_ovf/key_drop (1-cycle event pulses).
module morse_key_ctrl
    import morse_key_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int TW          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed_flag,
    input  logic [3:0] keyboard_val,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [4:0] code_bits,
    output logic [2:0] code_len,
    output logic [2:0] sym_count,
    output logic       err_ovf,
    output logic       key_drop
);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LEN_MAX = 3'(MAX_SYM);

    logic key_ev;

    key_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .flag_in (key_pressed_flag),
        .rise    (key_ev)
    );

    state_e        state_q, state_d;
    logic [4:0]    bits_q, bits_d;
    logic [2:0]    len_q, len_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          drop_q, drop_d;
    logic          vld_q, vld_d;
    logic [4:0]    obits_q, obits_d;
    logic [2:0]    olen_q, olen_d;
    logic          do_submit;

    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        len_d     = len_q;
        cnt_d     = '0;
        err_d     = 1'b0;
        drop_d    = 1'b0;
        do_submit = 1'b0;

        case (state_q)
            ST_OUTPUT: begin
                drop_d = key_ev;
                if (code_ready) begin
                    bits_d  = '0;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (key_ev) begin
                    // Any event, even an ignored code, restarts the idle timer and
                    // takes priority over a timeout landing in the same cycle.
                    case (keyboard_val)
                        KEY_DOT, KEY_DASH: begin
                            if (len_q == LEN_MAX) begin
                                err_d = 1'b1;
                            end else begin
                                bits_d[len_q] = (keyboard_val == KEY_DASH);
                                len_d         = len_q + 3'd1;
                                state_d       = ST_COLLECT;
                            end
                        end
                        KEY_BS: begin
                            if (len_q != 3'd0) begin
                                bits_d[len_q - 3'd1] = 1'b0;
                                len_d                = len_q - 3'd1;
                                if (len_q == 3'd1) state_d = ST_IDLE;
                            end
                        end
                        KEY_CLR: begin
                            bits_d  = '0;
                            len_d   = '0;
                            state_d = ST_IDLE;
                        end
                        KEY_SUBMIT: begin
                            do_submit = (state_q == ST_COLLECT);
                        end
                        default: ;
                    endcase
                end else if (state_q == ST_COLLECT) begin
                    if (cnt_q == TO_LAST) do_submit = 1'b1;
                    else                  cnt_d     = cnt_q + TW'(1);
                end
                if (do_submit) state_d = ST_OUTPUT;
            end
        endcase

        // Output word is registered and forced to zero outside OUTPUT.
        vld_d   = (state_d == ST_OUTPUT);
        obits_d = vld_d ? bits_d : 5'd0;
        olen_d  = vld_d ? len_d  : 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bits_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            vld_q   <= 1'b0;
            obits_q <= '0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            vld_q   <= vld_d;
            obits_q <= obits_d;
            olen_q  <= olen_d;
        end
    end

    assign code_valid = vld_q;
    assign code_bits  = obits_q;
    assign code_len   = olen_q;
    assign sym_count  = len_q;
    assign err_ovf    = err_q;
    assign key_drop   = drop_q;

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Testbench for morse_key_ctrl: directed scenarios plus random presses against a queue-based model.
// Ports: none (top-level bench).
// Drives inputs #1 after the rising edge and compares outputs there.
module tb_morse_key_ctrl;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_pressed_flag;
    logic [3:0] keyboard_val;
    logic       code_valid;
    logic       code_ready;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic [2:0] sym_count;
    logic       err_ovf;
    logic       key_drop;

    morse_key_ctrl #(.TIMEOUT_CYC(TO), .TW(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .key_pressed_flag (key_pressed_flag),
        .keyboard_val     (keyboard_val),
        .code_valid       (code_valid),
        .code_ready       (code_ready),
        .code_bits        (code_bits),
        .code_len         (code_len),
        .sym_count        (sym_count),
        .err_ovf          (err_ovf),
        .key_drop         (key_drop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: symbol queue plus pending output word.
    bit mq[$];
    bit m_vld;
    int m_bits, m_len, m_idle;
    bit m_err, m_drop;
    bit fh[$];          // flag value seen at each edge since reset release
    bit rnd_rdy = 0;

    // Observation helpers for directed scenarios.
    bit seen_vld;
    int last_bits, last_len, n_err, n_drop;

    task automatic model_clear();
        mq.delete();
        m_vld = 0; m_bits = 0; m_len = 0; m_idle = 0; m_err = 0; m_drop = 0;
        fh.delete();
    endtask

    task automatic model_submit();
        m_vld  = 1;
        m_bits = 0;
        foreach (mq[i]) m_bits += int'(mq[i]) << i;
        m_len  = mq.size();
        m_idle = 0;
    endtask

    task automatic model_edge(input bit ev, input logic [3:0] k, input bit rdy);
        m_err  = 0;
        m_drop = 0;
        if (m_vld) begin
            if (ev) m_drop = 1;
            if (rdy) begin
                m_vld = 0;
                mq.delete();
            end
        end else if (ev) begin
            m_idle = 0;
            case (k)
                4'h1, 4'h2: if (mq.size() < 5) mq.push_back(k == 4'h2); else m_err = 1;
                4'hE: if (mq.size() > 0) void'(mq.pop_back());
                4'hD: mq.delete();
                4'hF: if (mq.size() > 0) model_submit();
                default: ;
            endcase
        end else if (mq.size() > 0) begin
            if (m_idle == TO - 1) model_submit();
            else m_idle++;
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic compare_all();
        check_val("code_valid", int'(code_valid), int'(m_vld));
        check_val("code_bits",  int'(code_bits),  m_vld ? m_bits : 0);
        check_val("code_len",   int'(code_len),   m_vld ? m_len  : 0);
        check_val("sym_count",  int'(sym_count),  mq.size());
        check_val("err_ovf",    int'(err_ovf),    int'(m_err));
        check_val("key_drop",   int'(key_drop),   int'(m_drop));
    endtask

    // One clock: sample inputs, advance to the edge, update model, compare.
    task automatic step();
        bit ev;
        logic [3:0] k;
        bit r;
        int j;
        if (rnd_rdy) code_ready = ($urandom % 3) != 0;
        fh.push_back(key_pressed_flag);
        k = keyboard_val;
        r = code_ready;
        j = fh.size();
        // Synchronizer latency: the event lands two edges after the flag is first seen high,
        // and needs a genuine low sample just before it.
        ev = (j >= 4) && fh[j-3] && !fh[j-4];
        @(posedge clk);
        #1;
        model_edge(ev, k, r);
        compare_all();
        if (code_valid) begin
            seen_vld  = 1;
            last_bits = code_bits;
            last_len  = code_len;
        end
        if (err_ovf)  n_err++;
        if (key_drop) n_drop++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [3:0] k, input int hold = 4, input int gap = 4);
        keyboard_val     = k;
        key_pressed_flag = 1'b1;
        steps(hold);
        key_pressed_flag = 1'b0;
        steps(gap);
    endtask

    task automatic clear_obs();
        seen_vld = 0; last_bits = -1; last_len = -1; n_err = 0; n_drop = 0;
    endtask

    // Assert reset away from the edge; flag is left as the caller set it.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_valid", int'(code_valid), 0);
        check_val("rst_bits",  int'(code_bits),  0);
        check_val("rst_len",   int'(code_len),   0);
        check_val("rst_sym",   int'(sym_count),  0);
        check_val("rst_err",   int'(err_ovf),    0);
        check_val("rst_drop",  int'(key_drop),   0);
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_pressed_flag = 1'b0; keyboard_val = 4'h0; code_ready = 1'b1;
        model_clear();
        clear_obs();
        #2;
        do_reset();
        steps(4);

        // 1,2,2,F with ready high
        clear_obs();
        press(4'h1); press(4'h2); press(4'h2); press(4'hF);
        check_val("s1_seen",  int'(seen_vld), 1);
        check_val("s1_bits",  last_bits, 5'b00110);
        check_val("s1_len",   last_len, 3);
        check_val("s1_sym",   int'(sym_count), 0);

        // Overflow: six symbols, then submit held with ready low
        clear_obs();
        code_ready = 1'b0;
        press(4'h2); press(4'h2); press(4'h2); press(4'h2); press(4'h2); press(4'h1);
        check_val("s2_err",  n_err, 1);
        check_val("s2_sym",  int'(sym_count), 5);
        press(4'hF);
        check_val("s2_bits", int'(code_bits), 5'b11111);
        check_val("s2_len",  int'(code_len), 5);

        // Drops while valid stalls, then handshake
        clear_obs();
        steps(4);
        press(4'h1); press(4'h2);
        check_val("s3_drop", n_drop, 2);
        check_val("s3_stay", int'(code_bits), 5'b11111);
        code_ready = 1'b1;
        steps(2);
        check_val("s3_empty", int'(sym_count), 0);
        check_val("s3_vld",   int'(code_valid), 0);

        // Auto-submit after idle timeout
        clear_obs();
        press(4'h1);
        steps(TO);
        check_val("s4_seen", int'(seen_vld), 1);
        check_val("s4_bits", last_bits, 0);
        check_val("s4_len",  last_len, 1);

        // Second press lands exactly on the last timeout count and must win
        clear_obs();
        steps(3);
        press(4'h1);
        steps(TO - 8);
        press(4'h2);
        check_val("s5_seen", int'(seen_vld), 0);
        check_val("s5_sym",  int'(sym_count), 2);
        press(4'hD);
        check_val("s5_clr",  int'(sym_count), 0);

        // Backspace to empty, then submit is a no-op
        clear_obs();
        press(4'h2); press(4'h1); press(4'hE); press(4'hE); press(4'hE);
        check_val("s6_sym",  int'(sym_count), 0);
        press(4'hF);
        steps(4);
        check_val("s6_seen", int'(seen_vld), 0);

        // Reset mid-OUTPUT with the flag held high
        code_ready = 1'b0;
        press(4'h1); press(4'hF);
        keyboard_val     = 4'h2;
        key_pressed_flag = 1'b1;
        steps(4);
        do_reset();
        clear_obs();
        steps(10);
        check_val("s7_sym",  int'(sym_count), 0);
        key_pressed_flag = 1'b0;
        steps(3);
        code_ready = 1'b1;
        press(4'h1);
        check_val("s7_sym1", int'(sym_count), 1);
        press(4'hD);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            logic [3:0] k;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: k = 4'h1;
                3, 4:    k = 4'h2;
                5:       k = 4'hE;
                6:       k = 4'hF;
                7:       k = 4'hD;
                default: k = 4'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) rnd_rdy = ~rnd_rdy;
            if (!rnd_rdy) code_ready = 1'b1;
            press(k, $urandom_range(3, 6), $urandom_range(1, 8));
            if ($urandom_range(0, 24) == 0) steps(TO + 10);
            if ($urandom_range(0, 59) == 0) begin
                key_pressed_flag = $urandom_range(0, 1);
                do_reset();
                steps(5);
                key_pressed_flag = 1'b0;
                steps(3);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
